pingpong_sram_ctrl: RTL and testbench

Controller that drives a two-bank ping-pong SRAM pair, where each bank has a dedicated read port and write port. The write port is shared by both banks, and each bank is selected by its own cs/oe/we pins.
A producer layer streams one frame into one bank while a consumer layer randomly reads the previously committed frame from the other bank. The banks then swap.
The block owns bank ownership, address generation, SRAM pin timing and read-data steering.

---
 rtl/pingpong_sram_if.sv | 49 ++++
 rtl/pingpong_sram_ctrl.sv | 137 +++++++++++++
 tb/tb_pingpong_sram_ctrl.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/pingpong_sram_if.sv
// Bundle of producer, consumer and SRAM pin signals for the ping-pong SRAM controller.
// master = controller side, slave = producer/consumer/SRAM side.
interface pingpong_sram_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
);
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;

    logic              rd_avail;
    logic [ADDR_W:0]   rd_len;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_done;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;

    logic              cs1_rd, oe1_rd, we1_rd;
    logic              cs1_wr, oe1_wr, we1_wr;
    logic              cs2_rd, oe2_rd, we2_rd;
    logic              cs2_wr, oe2_wr, we2_wr;
    logic [ADDR_W-1:0] addr_rd;
    logic [ADDR_W-1:0] addr_wr;
    logic [DATA_W-1:0] data_wr;
    logic [DATA_W-1:0] data1_rd;
    logic [DATA_W-1:0] data2_rd;

    modport master (
        input  wr_valid, wr_data, wr_last,
        input  rd_en, rd_addr, rd_done,
        input  data1_rd, data2_rd,
        output wr_ready, rd_avail, rd_len, rd_data, rd_data_valid,
        output cs1_rd, oe1_rd, we1_rd, cs1_wr, oe1_wr, we1_wr,
        output cs2_rd, oe2_rd, we2_rd, cs2_wr, oe2_wr, we2_wr,
        output addr_rd, addr_wr, data_wr
    );

    modport slave (
        output wr_valid, wr_data, wr_last,
        output rd_en, rd_addr, rd_done,
        output data1_rd, data2_rd,
        input  wr_ready, rd_avail, rd_len, rd_data, rd_data_valid,
        input  cs1_rd, oe1_rd, we1_rd, cs1_wr, oe1_wr, we1_wr,
        input  cs2_rd, oe2_rd, we2_rd, cs2_wr, oe2_wr, we2_wr,
        input  addr_rd, addr_wr, data_wr
    );
endinterface

// File: rtl/pingpong_sram_ctrl.sv
// Ping-pong controller for two SRAM banks: producer fills one bank while the
// consumer randomly reads the committed frame in the other, then the banks swap.
module pingpong_sram_ctrl #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    pingpong_sram_if.master  bus
);
    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_t;

    bank_st_t          bank_st_q [2];
    bank_st_t          bank_st_d [2];
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W:0]   len_q [2];

    logic              accept_p0, close_p0, rd_hit_p0, release_p0, rd_avail_p0;
    logic              vld_p1, sel_p1;
    logic              vld_p2;
    logic [DATA_W-1:0] data_p2;

    // ---- p0: request decode, combinational from bank state ----
    assign bus.wr_ready = (bank_st_q[wr_bank_q] != FULL);
    assign rd_avail_p0  = (bank_st_q[rd_bank_q] == FULL);
    assign bus.rd_avail = rd_avail_p0;
    assign bus.rd_len   = rd_avail_p0 ? len_q[rd_bank_q] : '0;

    assign accept_p0  = bus.wr_valid & bus.wr_ready;
    assign close_p0   = accept_p0 & (bus.wr_last | (wr_cnt_q == {ADDR_W{1'b1}}));
    assign rd_hit_p0  = bus.rd_en & rd_avail_p0 & ({1'b0, bus.rd_addr} < bus.rd_len);
    assign release_p0 = bus.rd_done & rd_avail_p0;

    // Accept needs a non-FULL write bank and release needs a FULL read bank,
    // so the two updates below never target the same bank.
    always_comb begin
        bank_st_d[0] = bank_st_q[0];
        bank_st_d[1] = bank_st_q[1];
        wr_bank_d    = wr_bank_q ^ close_p0;
        rd_bank_d    = rd_bank_q ^ release_p0;
        wr_cnt_d     = wr_cnt_q;
        if (accept_p0) begin
            bank_st_d[wr_bank_q] = close_p0 ? FULL : FILLING;
            wr_cnt_d             = close_p0 ? '0 : wr_cnt_q + 1'b1;
        end
        if (release_p0) begin
            bank_st_d[rd_bank_q] = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bank_st_q[0] <= EMPTY;
            bank_st_q[1] <= EMPTY;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= '0;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (close_p0) begin
            len_q[wr_bank_q] <= {1'b0, wr_cnt_q} + 1'b1;
        end
    end

    // ---- p1: registered SRAM pins ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.cs1_wr  <= 1'b0;
            bus.we1_wr  <= 1'b0;
            bus.cs2_wr  <= 1'b0;
            bus.we2_wr  <= 1'b0;
            bus.addr_wr <= '0;
            bus.data_wr <= '0;
            bus.cs1_rd  <= 1'b0;
            bus.oe1_rd  <= 1'b0;
            bus.cs2_rd  <= 1'b0;
            bus.oe2_rd  <= 1'b0;
            bus.addr_rd <= '0;
            vld_p1      <= 1'b0;
            sel_p1      <= 1'b0;
        end else begin
            bus.cs1_wr <= accept_p0 & ~wr_bank_q;
            bus.we1_wr <= accept_p0 & ~wr_bank_q;
            bus.cs2_wr <= accept_p0 &  wr_bank_q;
            bus.we2_wr <= accept_p0 &  wr_bank_q;
            if (accept_p0) begin
                bus.addr_wr <= wr_cnt_q;
                bus.data_wr <= bus.wr_data;
            end
            bus.cs1_rd <= rd_hit_p0 & ~rd_bank_q;
            bus.oe1_rd <= rd_hit_p0 & ~rd_bank_q;
            bus.cs2_rd <= rd_hit_p0 &  rd_bank_q;
            bus.oe2_rd <= rd_hit_p0 &  rd_bank_q;
            if (rd_hit_p0) begin
                bus.addr_rd <= bus.rd_addr;
            end
            vld_p1 <= rd_hit_p0;
            sel_p1 <= rd_bank_q;
        end
    end

    assign bus.oe1_wr = 1'b0;
    assign bus.oe2_wr = 1'b0;
    assign bus.we1_rd = 1'b0;
    assign bus.we2_rd = 1'b0;

    // ---- p2: read data steering and return ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2  <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                data_p2 <= sel_p1 ? bus.data2_rd : bus.data1_rd;
            end
        end
    end

    assign bus.rd_data       = data_p2;
    assign bus.rd_data_valid = vld_p2;

endmodule

// File: tb/tb_pingpong_sram_ctrl.sv
// Directed bench for pingpong_sram_ctrl: table of per-cycle vectors plus
// hand sequences for forced close, dropped reads and mid-operation reset.
module tb_pingpong_sram_ctrl;
    localparam int DW = 64;
    localparam int AW = 9;
    localparam logic [5:0] P1 = 6'b110000;
    localparam logic [5:0] P2 = 6'b000110;
    localparam logic [63:0] A = 64'hA000_0000_0000_0000;
    localparam logic [63:0] B = 64'hB000_0000_0000_0000;
    localparam logic [63:0] C = 64'hC000_0000_0000_0000;
    localparam logic [63:0] D = 64'hD000_0000_0000_0000;
    localparam logic [63:0] E = 64'hE000_0000_0000_0000;
    localparam logic [63:0] F = 64'hF000_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    pingpong_sram_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    pingpong_sram_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // SRAM bank models: synchronous write, asynchronous read while selected
    logic [DW-1:0] mem1 [512];
    logic [DW-1:0] mem2 [512];
    always @(posedge clk) begin
        if (bus.cs1_wr && bus.we1_wr) mem1[bus.addr_wr] <= bus.data_wr;
        if (bus.cs2_wr && bus.we2_wr) mem2[bus.addr_wr] <= bus.data_wr;
    end
    assign bus.data1_rd = (bus.cs1_rd && bus.oe1_rd) ? mem1[bus.addr_rd] : '0;
    assign bus.data2_rd = (bus.cs2_rd && bus.oe2_rd) ? mem2[bus.addr_rd] : '0;

    typedef struct {
        logic          wv;
        logic          wl;
        logic [63:0]   wd;
        logic          re;
        logic [8:0]    ra;
        logic          rdn;
        logic [127:0]  exp;
    } vec_t;

    vec_t vecs [18];

    function automatic logic [127:0] pk(input logic rdy, input logic [5:0] wp,
                                        input logic [8:0] aw, input logic av,
                                        input logic [9:0] len, input logic [5:0] rp,
                                        input logic [8:0] ar, input logic vld,
                                        input logic [63:0] rd);
        return {21'd0, rdy, wp, aw, av, len, rp, ar, vld, rd};
    endfunction

    function automatic vec_t mk(input logic wv, input logic wl, input logic [63:0] wd,
                                input logic re, input logic [8:0] ra, input logic rdn,
                                input logic [127:0] exp);
        vec_t v;
        v.wv = wv; v.wl = wl; v.wd = wd; v.re = re; v.ra = ra; v.rdn = rdn; v.exp = exp;
        return v;
    endfunction

    function automatic logic [127:0] obs();
        return pk(bus.wr_ready,
                  {bus.cs1_wr, bus.we1_wr, bus.oe1_wr, bus.cs2_wr, bus.we2_wr, bus.oe2_wr},
                  bus.addr_wr, bus.rd_avail, bus.rd_len,
                  {bus.cs1_rd, bus.oe1_rd, bus.we1_rd, bus.cs2_rd, bus.oe2_rd, bus.we2_rd},
                  bus.addr_rd, bus.rd_data_valid, bus.rd_data);
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", nm, got, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wv, input logic wl, input logic [63:0] wd,
                         input logic re, input logic [8:0] ra, input logic rdn);
        bus.wr_valid = wv; bus.wr_last = wl; bus.wr_data = wd;
        bus.rd_en = re; bus.rd_addr = ra; bus.rd_done = rdn;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                wv wl wd    re ra rdn   rdy wp  aw av len rp  ar vld rd
        vecs[0]  = mk(1, 0, A+0, 0, 0, 0, pk(1, P1, 0, 0, 0, 0,  0, 0, 0));
        vecs[1]  = mk(1, 0, A+1, 0, 0, 0, pk(1, P1, 1, 0, 0, 0,  0, 0, 0));
        vecs[2]  = mk(1, 0, A+2, 0, 0, 0, pk(1, P1, 2, 0, 0, 0,  0, 0, 0));
        vecs[3]  = mk(1, 1, A+3, 0, 0, 0, pk(1, P1, 3, 1, 4, 0,  0, 0, 0));
        vecs[4]  = mk(0, 0, 0,   1, 2, 0, pk(1, 0,  3, 1, 4, P1, 2, 0, 0));
        vecs[5]  = mk(0, 0, 0,   0, 0, 0, pk(1, 0,  3, 1, 4, 0,  2, 1, A+2));
        vecs[6]  = mk(1, 0, B+0, 1, 0, 0, pk(1, P2, 0, 1, 4, P1, 0, 0, A+2));
        vecs[7]  = mk(1, 0, B+1, 1, 1, 0, pk(1, P2, 1, 1, 4, P1, 1, 1, A+0));
        vecs[8]  = mk(1, 1, B+2, 1, 2, 0, pk(0, P2, 2, 1, 4, P1, 2, 1, A+1));
        vecs[9]  = mk(1, 0, C+0, 1, 3, 0, pk(0, 0,  2, 1, 4, P1, 3, 1, A+2));
        vecs[10] = mk(1, 0, C+0, 0, 0, 0, pk(0, 0,  2, 1, 4, 0,  3, 1, A+3));
        vecs[11] = mk(1, 0, C+0, 0, 0, 1, pk(1, 0,  2, 1, 3, 0,  3, 0, A+3));
        vecs[12] = mk(1, 0, C+0, 0, 0, 0, pk(1, P1, 0, 1, 3, 0,  3, 0, A+3));
        vecs[13] = mk(1, 1, C+1, 1, 1, 1, pk(1, P1, 1, 1, 2, P2, 1, 0, A+3));
        vecs[14] = mk(0, 0, 0,   0, 0, 0, pk(1, 0,  1, 1, 2, 0,  1, 1, B+1));
        vecs[15] = mk(0, 0, 0,   1, 1, 0, pk(1, 0,  1, 1, 2, P1, 1, 0, B+1));
        vecs[16] = mk(0, 0, 0,   0, 0, 0, pk(1, 0,  1, 1, 2, 0,  1, 1, C+1));
        vecs[17] = mk(0, 0, 0,   0, 0, 1, pk(1, 0,  1, 0, 0, 0,  1, 0, C+1));

        drive(0, 0, 0, 0, 0, 0);
        step();
        step();
        chk("reset_outputs", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("reset_data_wr", {64'd0, bus.data_wr}, 128'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].wv, vecs[i].wl, vecs[i].wd, vecs[i].re, vecs[i].ra, vecs[i].rdn);
            step();
            chk($sformatf("vec%0d", i), obs(), vecs[i].exp);
        end

        // Forced close: 512 words into bank2 with wr_last never set
        for (int i = 0; i < 512; i++) begin
            drive(1, 0, D + 64'(i), 0, 0, 0);
            step();
            if (i == 0)
                chk("fc_first_pins", {bus.cs2_wr, bus.we2_wr, bus.cs1_wr, bus.addr_wr}, {1'b1, 1'b1, 1'b0, 9'd0});
            if (i == 510)
                chk("fc_not_yet_avail", bus.rd_avail, 0);
            if (i == 511) begin
                chk("fc_last_pins", {bus.cs2_wr, bus.we2_wr, bus.addr_wr}, {1'b1, 1'b1, 9'd511});
                chk("fc_avail_len", {bus.rd_avail, bus.rd_len}, {1'b1, 10'd512});
                chk("fc_wr_ready", bus.wr_ready, 1);
            end
        end
        drive(0, 0, 0, 1, 511, 0);
        step();
        chk("fc_rd_pins", {bus.cs2_rd, bus.oe2_rd, bus.we2_rd, bus.cs1_rd, bus.addr_rd},
            {1'b1, 1'b1, 1'b0, 1'b0, 9'd511});
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("fc_rd_data", {bus.rd_data_valid, bus.rd_data}, {1'b1, D + 64'd511});

        // Reads dropped while nothing is readable
        drive(0, 0, 0, 0, 0, 1);
        step();
        chk("rel_avail_low", {bus.rd_avail, bus.rd_len}, 0);
        drive(0, 0, 0, 1, 0, 0);
        step();
        chk("noavail_pins", {bus.cs1_rd, bus.oe1_rd, bus.cs2_rd, bus.oe2_rd}, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("noavail_valid", bus.rd_data_valid, 0);

        // Two-word frame into bank1, then out-of-range reads
        drive(1, 0, E + 0, 0, 0, 0);
        step();
        drive(1, 1, E + 1, 0, 0, 0);
        step();
        chk("e_avail_len", {bus.rd_avail, bus.rd_len, bus.cs1_wr, bus.addr_wr}, {1'b1, 10'd2, 1'b1, 9'd1});
        drive(0, 0, 0, 1, 2, 0);
        step();
        chk("oor2_pins", {bus.cs1_rd, bus.oe1_rd, bus.cs2_rd, bus.oe2_rd}, 0);
        drive(0, 0, 0, 1, 300, 0);
        step();
        chk("oor300_pins", {bus.cs1_rd, bus.oe1_rd, bus.cs2_rd, bus.oe2_rd, bus.rd_data_valid}, 0);
        drive(0, 0, 0, 1, 1, 0);
        step();
        chk("oor_valid", bus.rd_data_valid, 0);
        chk("e_rd_pins", {bus.cs1_rd, bus.oe1_rd, bus.addr_rd}, {1'b1, 1'b1, 9'd1});
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("e_rd_data", {bus.rd_data_valid, bus.rd_data}, {1'b1, E + 64'd1});

        // Reset during a partial bank2 frame with a read in flight
        drive(1, 0, F + 0, 0, 0, 0);
        step();
        drive(1, 0, F + 1, 1, 0, 0);
        step();
        chk("inflight_pins", {bus.cs2_wr, bus.cs1_rd, bus.addr_wr}, {1'b1, 1'b1, 9'd1});
        drive(0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        chk("midrst_outputs", obs(), pk(1, 0, 0, 0, 0, 0, 0, 0, 0));
        chk("midrst_data_wr", {64'd0, bus.data_wr}, 128'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_no_valid", {bus.rd_data_valid, bus.rd_avail, bus.wr_ready}, {1'b0, 1'b0, 1'b1});
        drive(1, 0, F + 7, 0, 0, 0);
        step();
        chk("postrst_write", {bus.cs1_wr, bus.we1_wr, bus.cs2_wr, bus.addr_wr, bus.data_wr},
            {1'b1, 1'b1, 1'b0, 9'd0, F + 64'd7});
        drive(0, 0, 0, 0, 0, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
